// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and constants for the D-cache main-memory responder:
//            FSM state and operation encodings, default geometry and the width
//            of the latency down-counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    // Default geometry; the responder recomputes these from its own parameters.
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned WORD_OFF_W     = $clog2(DEF_LINE_WORDS);
    localparam int unsigned LINE_W         = DEF_DATA_W * DEF_LINE_WORDS;

    // Latency counter width; covers the legal LATENCY range 1..15.
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    // Value loaded into the down-counter on accept.
    function automatic logic [CNT_W-1:0] lat_preload(input int unsigned lat);
        return CNT_W'(lat - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_line_store.sv
// ============================================================================
// Module   : dmem_line_store
// Purpose  : Single-port backing line store, 2**INDEX_W lines of LINE_W bits.
//            Synchronous write, registered read. The read register only loads
//            when rd_en_i is high, so it doubles as the responder's read-data
//            output and holds its value between reads. Array is never reset.
// Ports    : clk        - clock
//            rst_n      - synchronous active-low reset (read register only)
//            rd_en_i    - load read register from line idx_i
//            wr_en_i    - write wdata_i into line idx_i
//            idx_i      - line index
//            wdata_i    - write line
//            rdata_o    - registered read line
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_line_store #(
    parameter int unsigned LINE_W  = 64,
    parameter int unsigned INDEX_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en_i,
    input  logic               wr_en_i,
    input  logic [INDEX_W-1:0] idx_i,
    input  logic [LINE_W-1:0]  wdata_i,
    output logic [LINE_W-1:0]  rdata_o
);

    logic [LINE_W-1:0] lines_q [0:(2**INDEX_W)-1];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            lines_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= lines_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Purpose  : Main-memory responder for the D-cache miss controller. Accepts a
//            line read (mem_re) or write-back (mem_we) in IDLE, stalls LATENCY
//            cycles, then pulses drdy for one cycle. The store access happens
//            on the edge entering RESP.
// Config   : DMEM_PERF_CNT_EN - when defined, rd_count/wr_count count completed
//            reads/writes (16-bit wrap); otherwise both are tied to zero.
// Ports    : clk, rst_n (sync active-low), mem_re, mem_we, mem_addr (word addr),
//            mem_wdata (line), mem_rdata (line, held until next read), drdy,
//            busy (combinational, state != IDLE), proto_err (sticky),
//            rd_count, wr_count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned INDEX_W    = 12,
    parameter int unsigned LATENCY    = 4     // legal range 1..15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_re,
    input  logic                         mem_we,
    input  logic [15:0]                  mem_addr,
    input  logic [DATA_W*LINE_WORDS-1:0] mem_wdata,
    output logic [DATA_W*LINE_WORDS-1:0] mem_rdata,
    output logic                         drdy,
    output logic                         busy,
    output logic                         proto_err,
    output logic [15:0]                  rd_count,
    output logic [15:0]                  wr_count
);

    localparam int unsigned      C_LINE_W   = DATA_W * LINE_WORDS;
    localparam int unsigned      C_OFF_W    = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0] C_CNT_INIT = lat_preload(LATENCY);
    localparam bit               C_LAT_ONE  = (LATENCY == 1);

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [INDEX_W-1:0]   idx_q, idx_d;
    logic [C_LINE_W-1:0]  wdata_q, wdata_d;
    logic                 drdy_q;
    logic                 perr_q, perr_d;

    logic                 w_req;
    logic [INDEX_W-1:0]   w_addr_idx;
    logic                 w_enter_resp;
    logic [INDEX_W-1:0]   w_store_idx;
    logic [C_LINE_W-1:0]  w_store_wdata;
    logic                 w_store_rd;
    logic                 w_store_wr;

    assign w_req      = mem_re | mem_we;
    assign w_addr_idx = mem_addr[C_OFF_W +: INDEX_W];

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        wdata_d       = wdata_q;
        perr_d        = perr_q;
        w_enter_resp  = 1'b0;
        // Outside IDLE the store sees the latched request; in IDLE it sees the
        // live inputs so a LATENCY==1 access can complete on the accept edge.
        w_store_idx   = idx_q;
        w_store_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                w_store_idx   = w_addr_idx;
                w_store_wdata = mem_wdata;
                if (w_req) begin
                    // Write wins when both are raised together.
                    op_d    = mem_we ? OP_WR : OP_RD;
                    idx_d   = w_addr_idx;
                    wdata_d = mem_wdata;
                    cnt_d   = C_CNT_INIT;
                    if (mem_re && mem_we) begin
                        perr_d = 1'b1;
                    end
                    if (C_LAT_ONE) begin
                        state_d      = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // Leave on the edge where the counter would reach zero, so the
                // drdy cycle is the LATENCY-th cycle after the accept edge.
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d      = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Store write is masked by reset so a reset on the RESP edge commits nothing.
    assign w_store_rd = w_enter_resp && (op_d == OP_RD);
    assign w_store_wr = w_enter_resp && (op_d == OP_WR) && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_RD;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            drdy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            drdy_q  <= w_enter_resp;
            perr_q  <= perr_d;
        end
    end

    dmem_line_store #(
        .LINE_W  (C_LINE_W),
        .INDEX_W (INDEX_W)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en_i (w_store_rd),
        .wr_en_i (w_store_wr),
        .idx_i   (w_store_idx),
        .wdata_i (w_store_wdata),
        .rdata_o (mem_rdata)
    );

    assign drdy      = drdy_q;
    assign busy      = (state_q != IDLE);
    assign proto_err = perr_q;

`ifdef DMEM_PERF_CNT_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == RESP) begin
            if (op_q == OP_WR) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

`default_nettype wire
